bsg_clk_gen_pearl_tag_driver: RTL and testbench

Single-clock serializer that turns parallel bsg_tag write requests into the one-bit bsg_tag packet stream consumed by the clock-generator pearl's tag_data_i/tag_clk_i inputs. It sits directly upstream of the pearl, for example in a test harness, a boot ROM sequencer or an on-chip config master. It provides a valid/ready request port and emits exactly one packet per accepted request, with a guaranteed idle gap between packets.

---
 rtl/bsg_clk_gen_pearl_pkg.sv | 29 ++
 rtl/bsg_clk_gen_pearl_tag_shifter.sv | 37 +++
 rtl/bsg_clk_gen_pearl_tag_driver.sv | 121 ++++++++++++
 tb/tb_bsg_clk_gen_pearl_tag_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bsg_clk_gen_pearl_pkg.sv
// bsg_clk_gen_pearl_pkg: shared state enum, request struct macro, pearl node offsets and width helpers.
// Request struct layout: {id, data_not_reset, len, payload}.
// The payload field holds 2^lgw - 1 bits.
`define DECLARE_BSG_CLK_GEN_PEARL_TAG_REQ_S(idw, lgw) \
    typedef struct packed { \
        logic [(idw)-1:0] id; \
        logic data_not_reset; \
        logic [(lgw)-1:0] len; \
        logic [(2**(lgw))-2:0] payload; \
    } bsg_clk_gen_pearl_tag_req_s

package bsg_clk_gen_pearl_pkg;
    typedef enum logic [2:0] {IDLE, START, ID, DNR, LEN, PAY, GAP} bsg_clk_gen_pearl_tag_driver_state_e;
    localparam int tag_node_osc           = 0;
    localparam int tag_node_osc_trigger   = 1;
    localparam int tag_node_ds            = 2;
    localparam int tag_node_sel           = 3;
    localparam int tag_node_async_reset   = 4;
    localparam int tag_node_monitor_reset = 5;
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > d) ? m : d;
    endfunction
endpackage

// File: rtl/bsg_clk_gen_pearl_tag_shifter.sv
// bsg_clk_gen_pearl_tag_shifter: loadable right-shift register with a bits-remaining down-counter.
// Ports:
//   clk_i, reset_i : clock and asynchronous active-high reset
//   load_i         : capture data_i and cnt_i
//   shift_i        : shift right by one and decrement the count
//   bit_o          : current LSB, the next bit to be sent
//   done_o         : no bits left to send
module bsg_clk_gen_pearl_tag_shifter #(
    parameter int width_p     = 1,
    parameter int cnt_width_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic [width_p-1:0]     data_i,
    input  logic [cnt_width_p-1:0] cnt_i,
    output logic                   bit_o,
    output logic                   done_o
);
    logic [width_p-1:0] data_r;
    logic [cnt_width_p-1:0] cnt_r;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r <= '0;
            cnt_r  <= '0;
        end else if (load_i) begin
            data_r <= data_i;
            cnt_r  <= cnt_i;
        end else if (shift_i) begin
            data_r <= data_r >> 1;
            cnt_r  <= cnt_r - 1'b1;
        end
    end
    assign bit_o  = data_r[0];
    assign done_o = (cnt_r == '0);
endmodule

// File: rtl/bsg_clk_gen_pearl_tag_driver.sv
// bsg_clk_gen_pearl_tag_driver: serializes parallel bsg_tag requests into the one-bit tag packet stream.
// Ports:
//   clk_i, reset_i       : serial clock and asynchronous active-high reset
//   v_i, ready_and_o     : request handshake, ready only while idle
//   id_i, data_not_reset_i, len_i, payload_i : request fields, captured on acceptance
//   tag_data_o           : registered serial stream
//   busy_o               : high from acceptance until the last gap bit
module bsg_clk_gen_pearl_tag_driver
    import bsg_clk_gen_pearl_pkg::*;
#(
    parameter int els_p      = 8,
    parameter int lg_width_p = 4,
    parameter int gap_p      = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            v_i,
    output logic                            ready_and_o,
    input  logic [safe_clog2(els_p)-1:0]    id_i,
    input  logic                            data_not_reset_i,
    input  logic [lg_width_p-1:0]           len_i,
    input  logic [(2**lg_width_p)-2:0]      payload_i,
    output logic                            tag_data_o,
    output logic                            busy_o
);
    localparam int idw = safe_clog2(els_p);
    localparam int pw  = (2**lg_width_p) - 1;
    localparam int cw  = safe_clog2(max4(idw, lg_width_p, pw, gap_p) + 1);

    `DECLARE_BSG_CLK_GEN_PEARL_TAG_REQ_S(idw, lg_width_p);

    bsg_clk_gen_pearl_tag_req_s req;
    bsg_clk_gen_pearl_tag_driver_state_e state_r, state_n;
    logic dnr_r, bit_n, load, gap_load;
    logic id_shift, len_shift, pay_shift;
    logic id_bit, len_bit, pay_bit, id_done, len_done, pay_done;
    logic [lg_width_p-1:0] len_r;
    logic [cw-1:0] gap_r;

    assign req = '{id: id_i, data_not_reset: data_not_reset_i, len: len_i, payload: payload_i};
    assign load = (state_r == IDLE) & v_i;
    assign busy_o = (state_r != IDLE);
    assign ready_and_o = (state_r == IDLE) & ~reset_i;

    bsg_clk_gen_pearl_tag_shifter #(.width_p(idw), .cnt_width_p(cw)) id_sh (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load), .shift_i(id_shift),
        .data_i(req.id), .cnt_i(cw'(idw)), .bit_o(id_bit), .done_o(id_done));

    bsg_clk_gen_pearl_tag_shifter #(.width_p(lg_width_p), .cnt_width_p(cw)) len_sh (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load), .shift_i(len_shift),
        .data_i(req.len), .cnt_i(cw'(lg_width_p)), .bit_o(len_bit), .done_o(len_done));

    bsg_clk_gen_pearl_tag_shifter #(.width_p(pw), .cnt_width_p(cw)) pay_sh (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load), .shift_i(pay_shift),
        .data_i(req.payload), .cnt_i(cw'(req.len)), .bit_o(pay_bit), .done_o(pay_done));

    // bit_n is the bit shown during the state being entered; a field's shifter
    // shifts on the edge that puts its LSB on the line, so done means all sent.
    always_comb begin
        state_n   = state_r;
        bit_n     = 1'b0;
        id_shift  = 1'b0;
        len_shift = 1'b0;
        pay_shift = 1'b0;
        gap_load  = 1'b0;
        case (state_r)
            IDLE: begin
                state_n = v_i ? START : IDLE;
                bit_n   = v_i;
            end
            START: begin
                state_n  = ID;
                bit_n    = id_bit;
                id_shift = 1'b1;
            end
            ID: begin
                state_n  = id_done ? DNR : ID;
                bit_n    = id_done ? dnr_r : id_bit;
                id_shift = ~id_done;
            end
            DNR: begin
                state_n   = LEN;
                bit_n     = len_bit;
                len_shift = 1'b1;
            end
            LEN: begin
                state_n   = ~len_done ? LEN : (len_r != '0) ? PAY : GAP;
                bit_n     = ~len_done ? len_bit : (len_r != '0) & pay_bit;
                len_shift = ~len_done;
                pay_shift = len_done & (len_r != '0);
                gap_load  = len_done & (len_r == '0);
            end
            PAY: begin
                state_n   = pay_done ? GAP : PAY;
                bit_n     = ~pay_done & pay_bit;
                pay_shift = ~pay_done;
                gap_load  = pay_done;
            end
            GAP: state_n = (gap_r == '0) ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            tag_data_o <= 1'b0;
            dnr_r      <= 1'b0;
            len_r      <= '0;
            gap_r      <= '0;
        end else begin
            state_r    <= state_n;
            tag_data_o <= bit_n;
            if (load) begin
                dnr_r <= req.data_not_reset;
                len_r <= req.len;
            end
            gap_r <= gap_load ? cw'(gap_p - 1) : (gap_r != '0) ? gap_r - 1'b1 : gap_r;
        end
    end
endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_driver.sv
// tb_bsg_clk_gen_pearl_tag_driver: table vectors, corner sequences and random traffic against a bit-stream model.
module tb_bsg_clk_gen_pearl_tag_driver;
    logic clk = 1'b0, reset_i = 1'b1, v_i = 1'b0, data_not_reset_i = 1'b0;
    logic [2:0] id_i = '0;
    logic [3:0] len_i = '0;
    logic [14:0] payload_i = '0;
    logic ready_and_o, tag_data_o, busy_o;

    bsg_clk_gen_pearl_tag_driver #(.els_p(8), .lg_width_p(4), .gap_p(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
        .id_i(id_i), .data_not_reset_i(data_not_reset_i), .len_i(len_i),
        .payload_i(payload_i), .tag_data_o(tag_data_o), .busy_o(busy_o));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic        dnr;
        logic [3:0]  len;
        logic [14:0] pay;
        int          n;
        logic [31:0] bits;
    } vec_t;
    vec_t vecs[4];

    int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, act_n = 0;
    logic [31:0] act_v;
    logic exp_q[$];
    int acc_cyc[$];
    int acc_len[$];
    logic cur_bit = 1'b0, cur_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: an idle line accepts a valid request and queues its whole packet bit by bit.
    task automatic mon();
        cyc++;
        if (reset_i) begin
            chk("rst_data", tag_data_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_ready", ready_and_o, 0);
            exp_q.delete();
            cur_bit = 1'b0;
            cur_busy = 1'b0;
            act_n = 0;
            return;
        end
        chk("data", tag_data_o, cur_bit);
        chk("busy", busy_o, cur_busy);
        chk("ready", ready_and_o, !cur_busy);
        if (busy_o && act_n < 32) begin
            act_v[act_n] = tag_data_o;
            act_n++;
        end
        if (!cur_busy && v_i) begin
            exp_q.push_back(1'b1);
            for (int i = 0; i < 3; i++) exp_q.push_back(id_i[i]);
            exp_q.push_back(data_not_reset_i);
            for (int i = 0; i < 4; i++) exp_q.push_back(len_i[i]);
            for (int i = 0; i < int'(len_i); i++) exp_q.push_back(payload_i[i]);
            repeat (4) exp_q.push_back(1'b0);
            acc_cnt++;
            acc_cyc.push_back(cyc);
            acc_len.push_back(int'(len_i));
            act_n = 0;
            act_v = '0;
        end
        if (exp_q.size() > 0) begin
            cur_bit = exp_q.pop_front();
            cur_busy = 1'b1;
        end else begin
            cur_bit = 1'b0;
            cur_busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] id, input logic dnr, input logic [3:0] len, input logic [14:0] pay);
        int a0, t;
        id_i = id;
        data_not_reset_i = dnr;
        len_i = len;
        payload_i = pay;
        v_i = 1'b1;
        a0 = acc_cnt;
        t = 0;
        while (acc_cnt == a0 && t < 200) begin
            tick();
            t++;
        end
        if (acc_cnt == a0) chk("accept_timeout", 0, 1);
        v_i = 1'b0;
        id_i = 3'($urandom);
        data_not_reset_i = 1'($urandom);
        len_i = 4'($urandom);
        payload_i = 15'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((cur_busy || exp_q.size() > 0) && t < 200) begin
            tick();
            t++;
        end
        if (cur_busy) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        vecs[0] = '{id: 3'd5, dnr: 1'b1, len: 4'd3,  pay: 15'b110,   n: 16, bits: 32'h0C7B};
        vecs[1] = '{id: 3'd2, dnr: 1'b0, len: 4'd0,  pay: 15'h7FFF,  n: 13, bits: 32'h5};
        vecs[2] = '{id: 3'd7, dnr: 1'b1, len: 4'd15, pay: 15'h5555,  n: 28, bits: 32'h0AAABFF};
        vecs[3] = '{id: 3'd0, dnr: 1'b0, len: 4'd1,  pay: 15'h7FFE,  n: 14, bits: 32'h21};

        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        chk("ready_after_reset", ready_and_o, 1);

        for (int k = 0; k < 4; k++) begin
            send(vecs[k].id, vecs[k].dnr, vecs[k].len, vecs[k].pay);
            wait_idle();
            chk($sformatf("vec%0d_len", k), act_n, vecs[k].n);
            chk($sformatf("vec%0d_bits", k), act_v, vecs[k].bits);
            tick();
        end

        acc_cyc.delete();
        acc_len.delete();
        send(3'd1, 1'b1, 4'd2, 15'h3);
        send(3'd6, 1'b1, 4'd5, 15'h15);
        send(3'd3, 1'b0, 4'd0, 15'h0);
        wait_idle();
        for (int k = 1; k < 3; k++)
            chk($sformatf("b2b_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 1 + 1 + 3 + 1 + 4 + acc_len[k-1] + 4);

        send(3'd7, 1'b1, 4'd15, 15'h5555);
        repeat (11) tick();
        chk("pre_rst_bit", tag_data_o, 1);
        reset_i = 1'b1;
        #1;
        chk("async_rst_data", tag_data_o, 0);
        chk("async_rst_busy", busy_o, 0);
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        chk("ready_after_abort", ready_and_o, 1);
        send(vecs[0].id, vecs[0].dnr, vecs[0].len, vecs[0].pay);
        wait_idle();
        chk("post_rst_len", act_n, vecs[0].n);
        chk("post_rst_bits", act_v, vecs[0].bits);

        for (int k = 0; k < 40; k++) begin
            send(3'($urandom), 1'($urandom), 4'($urandom), 15'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
